// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes bclk/lrclk/dout into the clk domain, deserializes
// left/right words and presents sample pairs through a valid/ready handshake.
module i2s_rx #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_dout,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int unsigned      CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0] dout_sync_q, dout_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   done_ch_q, done_ch_d;
  logic                   done_ok_q, done_ok_d;
  logic [DATA_W-1:0]      word_q, word_d;
  logic [DATA_W-1:0]      stage_q, stage_d;
  logic                   left_pend_q, left_pend_d;
  logic                   pair_vld_q, pair_vld_d;
  logic [DATA_W-1:0]      pair_r_q, pair_r_d;
  logic [DATA_W-1:0]      left_q, left_d;
  logic [DATA_W-1:0]      right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic bclk_s, lr_s, dout_s, bclk_rise;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s      = lr_sync_q[SYNC_STAGES-1];
  assign dout_s    = dout_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;

  // Shift chains; the cast drops the oldest stage so SYNC_STAGES=1 also works.
  always_comb begin
    bclk_sync_d = SYNC_STAGES'({bclk_sync_q, i2s_bclk});
    lr_sync_d   = SYNC_STAGES'({lr_sync_q, i2s_lrclk});
    dout_sync_d = SYNC_STAGES'({dout_sync_q, i2s_dout});
  end

  // Bit-level front end: shift, count and detect word boundaries on bclk rises.
  always_comb begin
    bclk_prev_d = bclk_s;
    lr_prev_d   = lr_prev_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    done_ch_d   = done_ch_q;
    done_ok_d   = done_ok_q;
    word_d      = word_q;
    if (bclk_rise) begin
      shift_d   = {shift_q[DATA_W-2:0], dout_s};
      lr_prev_d = lr_s;
      if (lr_s != lr_prev_q) begin
        done_d    = 1'b1;
        done_ch_d = lr_prev_q;
        done_ok_d = (cnt_q == CNT_FULL);
        word_d    = {shift_q[DATA_W-2:0], dout_s};
        cnt_d     = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Word acceptance FSM: SYNC throws away the alignment word, RUN pairs L then R.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    left_pend_d = left_pend_q;
    pair_vld_d  = 1'b0;
    pair_r_d    = pair_r_q;
    frame_err_d = frame_err_q;
    if (done_q) begin
      case (state_q)
        ST_SYNC: state_d = ST_RUN;
        ST_RUN: begin
          if (!done_ok_q) begin
            frame_err_d = 1'b1;
            left_pend_d = 1'b0;
          end else if (!done_ch_q) begin
            stage_d     = word_q;
            left_pend_d = 1'b1;
          end else if (left_pend_q) begin
            pair_vld_d  = 1'b1;
            pair_r_d    = word_q;
            left_pend_d = 1'b0;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  // Output holding registers and handshake.
  always_comb begin
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (pair_vld_q) begin
      if (!valid_q || sample_ready) begin
        left_d  = stage_q;
        right_d = pair_r_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_SYNC;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      dout_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      done_ch_q   <= 1'b0;
      done_ok_q   <= 1'b0;
      word_q      <= '0;
      stage_q     <= '0;
      left_pend_q <= 1'b0;
      pair_vld_q  <= 1'b0;
      pair_r_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      dout_sync_q <= dout_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lr_prev_q   <= lr_prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      done_ch_q   <= done_ch_d;
      done_ok_q   <= done_ok_d;
      word_q      <= word_d;
      stage_q     <= stage_d;
      left_pend_q <= left_pend_d;
      pair_vld_q  <= pair_vld_d;
      pair_r_q    <= pair_r_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: an I2S transmitter model at 1.1 MHz bclk against
// a 44 MHz clk, driven from a frame table plus hand-timed corner sequences.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int unsigned DATA_W   = 16;
  localparam int          HALF_BIT = 20;

  logic              clk;
  logic              reset;
  logic              i2s_bclk, i2s_lrclk, i2s_dout;
  logic [DATA_W-1:0] left_data, right_data;
  logic              sample_valid, sample_ready, overrun, frame_err;

  i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_dout     (i2s_dout),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #11.364 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          lbits;
    logic        rdy;
    int          exp_hs;
    logic [15:0] hs_l;
    logic [15:0] hs_r;
    logic        end_v;
    logic [15:0] end_l;
    logic [15:0] end_r;
    logic        end_ovr;
    logic        end_ferr;
  } vec_t;

  vec_t vecs [10];

  int checks = 0;
  int errors = 0;

  // Handshake monitor sampled on the falling clk edge.
  int          hs_total = 0;
  int          vcyc_total = 0;
  logic [15:0] hs_l_m = '0;
  logic [15:0] hs_r_m = '0;
  always @(negedge clk) begin
    if (sample_valid) vcyc_total <= vcyc_total + 1;
    if (sample_valid && sample_ready) begin
      hs_total <= hs_total + 1;
      hs_l_m   <= left_data;
      hs_r_m   <= right_data;
    end
  end

  logic prev_lsb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bit_low(input logic lr, input logic d);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_dout  = d;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  task automatic bit_high();
    i2s_bclk = 1'b1;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  // One-bit I2S delay: the first period of each word carries the previous LSB.
  task automatic send_word(input logic lr, input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bit_low(lr, (i == 0) ? prev_lsb : w[nbits-i]);
      bit_high();
    end
    prev_lsb = w[0];
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits);
    send_word(1'b0, l, lbits);
    send_word(1'b1, r, 16);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},   32'(sample_valid), 32'd0);
    check({tag, "_left"},    32'(left_data),    32'd0);
    check({tag, "_right"},   32'(right_data),   32'd0);
    check({tag, "_overrun"}, 32'(overrun),      32'd0);
    check({tag, "_frame_err"}, 32'(frame_err),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          hs0, vc0;
    vec_t        v;
    logic [15:0] w;

    // Each row: frame sent, deliveries seen while it is on the wire, state at its end.
    vecs[0] = '{16'h1111, 16'h2222, 16, 1'b1, 0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'hA5C3, 16'h0F0F, 16, 1'b1, 0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h7FFF, 16, 1'b1, 1, 16'hA5C3, 16'h0F0F, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{16'h0001, 16'hFFFF, 16, 1'b1, 1, 16'h8000, 16'h7FFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 16, 1'b1, 1, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h5EAD, 16'hBEEF, 15, 1'b1, 1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{16'h1234, 16'h5678, 16, 1'b1, 0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h7FFF, 16, 1'b1, 1, 16'h1234, 16'h5678, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{16'h0001, 16'hFFFF, 16, 1'b0, 0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[9] = '{16'h0000, 16'h0000, 16, 1'b0, 0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1};

    reset        = 1'b1;
    i2s_bclk     = 1'b0;
    i2s_lrclk    = 1'b0;
    i2s_dout     = 1'b0;
    sample_ready = 1'b1;
    prev_lsb     = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      v            = vecs[i];
      sample_ready = v.rdy;
      hs0          = hs_total;
      vc0          = vcyc_total;
      send_frame(v.l, v.r, v.lbits);
      check($sformatf("row%0d_handshakes", i), 32'(hs_total - hs0), 32'(v.exp_hs));
      if (v.rdy) check($sformatf("row%0d_valid_cycles", i), 32'(vcyc_total - vc0), 32'(v.exp_hs));
      if (v.exp_hs > 0) begin
        check($sformatf("row%0d_hs_left", i),  32'(hs_l_m), 32'(v.hs_l));
        check($sformatf("row%0d_hs_right", i), 32'(hs_r_m), 32'(v.hs_r));
      end
      check($sformatf("row%0d_end_valid", i), 32'(sample_valid), 32'(v.end_v));
      if (v.end_v) begin
        check($sformatf("row%0d_end_left", i),  32'(left_data),  32'(v.end_l));
        check($sformatf("row%0d_end_right", i), 32'(right_data), 32'(v.end_r));
      end
      check($sformatf("row%0d_overrun", i),   32'(overrun),   32'(v.end_ovr));
      check($sformatf("row%0d_frame_err", i), 32'(frame_err), 32'(v.end_ferr));
    end

    // Reset in the middle of a right word while a pair is held and both flags are set.
    send_word(1'b0, 16'h1357, 16);
    w = 16'h2468;
    for (int i = 0; i < 8; i++) begin
      bit_low(1'b1, (i == 0) ? prev_lsb : w[16-i]);
      bit_high();
    end
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midword_reset");
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_dout  = 1'b0;
    prev_lsb  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("after_reset");

    sample_ready = 1'b1;
    hs0 = hs_total;
    send_frame(16'h1357, 16'h2468, 16);
    check("align_frame_handshakes", 32'(hs_total - hs0), 32'd0);
    sample_ready = 1'b0;
    send_frame(16'hABCD, 16'hEF01, 16);
    check("align_frame_not_delivered", 32'(sample_valid), 32'd0);
    send_frame(16'h3C3C, 16'hC3C3, 16);
    check("post_reset_valid", 32'(sample_valid), 32'd1);
    check("post_reset_left",  32'(left_data),    32'hABCD);
    check("post_reset_right", 32'(right_data),   32'hEF01);
    check("post_reset_overrun",   32'(overrun),   32'd0);
    check("post_reset_frame_err", 32'(frame_err), 32'd0);

    // The next pair loads 4 clk edges after the first synchronizer stage sees bclk rise.
    bit_low(1'b0, prev_lsb);
    i2s_bclk = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("edge_before_load_valid", 32'(sample_valid), 32'd1);
    check("edge_before_load_left",  32'(left_data),    32'hABCD);
    sample_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reload_valid",   32'(sample_valid), 32'd1);
    check("reload_left",    32'(left_data),    32'h3C3C);
    check("reload_right",   32'(right_data),   32'hC3C3);
    check("reload_overrun", 32'(overrun),      32'd0);
    @(negedge clk);
    check("reload_consumed_valid", 32'(sample_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
